// File: rtl/display_pkg.sv
// ============================================================================
// display_pkg
// Shared constants and FSM state encoding for the display-timing blocks.
// Revision: 1.0
// ============================================================================
`default_nettype none

package display_pkg;

   localparam int c_NUM_TASKS_DEFAULT         = 3;
   localparam int c_FRAME_COUNT_WIDTH_DEFAULT = 16;

   typedef logic [1:0] state_t;

   localparam state_t c_ST_IDLE   = 2'd0;
   localparam state_t c_ST_LAUNCH = 2'd1;
   localparam state_t c_ST_WAIT   = 2'd2;

   // Wide enough for up to eight tasks.
   typedef logic [2:0] task_idx_t;

endpackage

`default_nettype wire

// File: rtl/rise_detect.sv
// ============================================================================
// rise_detect
// Registered rising-edge detector; RESET_VALUE seeds the history flop so a
// level already high at reset release is not mistaken for an edge.
// Revision: 1.0
// ============================================================================
`default_nettype none

module rise_detect #(
   parameter logic RESET_VALUE = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic i_d,
   output logic o_rise
);

   logic r_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_q <= RESET_VALUE;
      end else begin
         r_q <= i_d;
      end
   end

   assign o_rise = i_d & ~r_q;

endmodule

`default_nettype wire

// File: rtl/vblank_scheduler.sv
// ============================================================================
// vblank_scheduler
// Sequences enabled game-logic tasks once per frame, starting on the vsync
// rising edge. Optional overrun detection via VBLANK_SCHEDULER_OVERRUN_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module vblank_scheduler
   import display_pkg::*;
#(
   parameter int NUM_TASKS         = c_NUM_TASKS_DEFAULT,
   parameter int FRAME_COUNT_WIDTH = c_FRAME_COUNT_WIDTH_DEFAULT
) (
   input  logic                         clk_rgb,
   input  logic                         rst,
   input  logic                         vs,
   input  logic                         de,
   input  logic [NUM_TASKS-1:0]         task_enable,
   output logic [NUM_TASKS-1:0]         task_start,
   input  logic [NUM_TASKS-1:0]         task_done,
   output logic                         busy,
   output logic [FRAME_COUNT_WIDTH-1:0] frame_count,
   output logic                         overrun,
   input  logic                         overrun_clear
);

   logic                         w_frame_start;
   state_t                       r_state;
   logic [NUM_TASKS-1:0]         r_mask;
   task_idx_t                    r_cur;
   logic [FRAME_COUNT_WIDTH-1:0] r_frame_count;
   task_idx_t                    w_first_idx;
   task_idx_t                    w_next_idx;
   logic                         w_has_next;
   logic                         w_cur_done;
   logic [NUM_TASKS-1:0]         w_start;
   logic                         w_active;

   // History flop resets high so vs held across reset release is not an edge.
   rise_detect #(
      .RESET_VALUE (1'b1)
   ) u_vs_rise (
      .clk    (clk_rgb),
      .rst    (rst),
      .i_d    (vs),
      .o_rise (w_frame_start)
   );

   always_comb begin
      w_first_idx = '0;
      for (int i = NUM_TASKS - 1; i >= 0; i--) begin
         if (task_enable[i]) begin
            w_first_idx = task_idx_t'(i);
         end
      end
   end

   always_comb begin
      w_next_idx = '0;
      w_has_next = 1'b0;
      for (int i = NUM_TASKS - 1; i >= 0; i--) begin
         if (r_mask[i] && (i > int'(r_cur))) begin
            w_next_idx = task_idx_t'(i);
            w_has_next = 1'b1;
         end
      end
   end

   always_comb begin
      w_cur_done = 1'b0;
      w_start    = '0;
      for (int i = 0; i < NUM_TASKS; i++) begin
         if (task_idx_t'(i) == r_cur) begin
            w_cur_done = task_done[i];
            w_start[i] = (r_state == c_ST_LAUNCH) && !rst;
         end
      end
   end

   always_ff @(posedge clk_rgb) begin
      if (rst) begin
         r_state       <= c_ST_IDLE;
         r_mask        <= '0;
         r_cur         <= '0;
         r_frame_count <= '0;
      end else begin
         case (r_state)
            c_ST_IDLE: begin
               if (w_frame_start) begin
                  r_mask <= task_enable;
                  if (|task_enable) begin
                     r_cur   <= w_first_idx;
                     r_state <= c_ST_LAUNCH;
                  end else begin
                     r_frame_count <= r_frame_count + FRAME_COUNT_WIDTH'(1);
                  end
               end
            end
            c_ST_LAUNCH: begin
               r_state <= c_ST_WAIT;
            end
            c_ST_WAIT: begin
               if (w_cur_done) begin
                  if (w_has_next) begin
                     r_cur   <= w_next_idx;
                     r_state <= c_ST_LAUNCH;
                  end else begin
                     r_state       <= c_ST_IDLE;
                     r_frame_count <= r_frame_count + FRAME_COUNT_WIDTH'(1);
                  end
               end
            end
            default: begin
               r_state <= c_ST_IDLE;
            end
         endcase
      end
   end

   assign w_active    = (r_state != c_ST_IDLE);
   assign busy        = w_active && !rst;
   assign task_start  = w_start;
   assign frame_count = r_frame_count;

`ifdef VBLANK_SCHEDULER_OVERRUN_EN
   logic r_overrun;

   // Set has priority over clear so a collision in the clear cycle is kept.
   always_ff @(posedge clk_rgb) begin
      if (rst) begin
         r_overrun <= 1'b0;
      end else if (w_active && (de || w_frame_start)) begin
         r_overrun <= 1'b1;
      end else if (overrun_clear) begin
         r_overrun <= 1'b0;
      end
   end

   assign overrun = r_overrun;
`else
   logic w_unused_ok;

   assign w_unused_ok = &{1'b0, de, overrun_clear};
   assign overrun     = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_vblank_scheduler.sv
// ============================================================================
// tb_vblank_scheduler
// Directed bench for vblank_scheduler with a start-pulse scoreboard.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_vblank_scheduler;

   localparam int NT  = 3;
   localparam int FCW = 8;

   logic           clk_rgb = 1'b0;
   logic           rst;
   logic           vs;
   logic           de;
   logic [NT-1:0]  task_enable;
   logic [NT-1:0]  task_start;
   logic [NT-1:0]  task_done;
   logic           busy;
   logic [FCW-1:0] frame_count;
   logic           overrun;
   logic           overrun_clear;

   int total = 0;
   int bad   = 0;
   int exp_q[$];
   int exp_fc = 0;
   int exp_ovr;

   always #5 clk_rgb = ~clk_rgb;

   vblank_scheduler #(
      .NUM_TASKS         (NT),
      .FRAME_COUNT_WIDTH (FCW)
   ) dut (
      .clk_rgb       (clk_rgb),
      .rst           (rst),
      .vs            (vs),
      .de            (de),
      .task_enable   (task_enable),
      .task_start    (task_start),
      .task_done     (task_done),
      .busy          (busy),
      .frame_count   (frame_count),
      .overrun       (overrun),
      .overrun_clear (overrun_clear)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Every start pulse must match the next expected task index in order.
   always @(negedge clk_rgb) begin
      int e;
      if (task_start !== '0) begin
         if (exp_q.size() == 0) begin
            check("start_unexpected", 32'(task_start), 32'd0);
         end else begin
            e = exp_q.pop_front();
            check("start_order", 32'(task_start), 32'(1) << e);
         end
      end
   end

   task automatic step();
      @(posedge clk_rgb);
      #1;
   endtask

   // Entered in the start cycle of task idx; done is driven 4 cycles later.
   task automatic run_task(input int idx, input logic [NT-1:0] stray, input bit glitch);
      for (int k = 1; k <= 4; k++) begin
         step();
         if (k == 1) begin
            check("busy_wait", 32'(busy), 32'd1);
            if (glitch) begin
               vs          = 1'b0;
               task_enable = '0;
            end
         end
         if (k == 2) begin
            task_done = stray;
            if (glitch) vs = 1'b1;
         end
         if (k == 3) task_done = '0;
         if (k == 4) task_done = NT'(1) << idx;
      end
      step();
      task_done = '0;
   endtask

   task automatic arm_frame(input logic [NT-1:0] mask);
      vs = 1'b0;
      step();
      task_enable = mask;
      vs          = 1'b1;
      for (int i = 0; i < NT; i++) begin
         if (mask[i]) exp_q.push_back(i);
      end
   endtask

   initial begin
`ifdef VBLANK_SCHEDULER_OVERRUN_EN
      exp_ovr = 1;
`else
      exp_ovr = 0;
`endif
      rst           = 1'b1;
      vs            = 1'b1;
      de            = 1'b0;
      overrun_clear = 1'b0;
      task_enable   = 3'b111;
      task_done     = '0;
      repeat (3) step();
      check("rst_start", 32'(task_start), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_fc", 32'(frame_count), 32'd0);
      check("rst_overrun", 32'(overrun), 32'd0);

      // vs held high across release must not launch anything
      rst = 1'b0;
      repeat (6) step();
      check("release_start", 32'(task_start), 32'd0);
      check("release_busy", 32'(busy), 32'd0);

      // Full mask, stray dones, restart attempt and mask change mid-sequence
      arm_frame(3'b111);
      check("busy_frame_cycle", 32'(busy), 32'd0);
      step();
      check("start0", 32'(task_start), 32'b001);
      check("busy_n1", 32'(busy), 32'd1);
      run_task(0, 3'b110, 1'b1);
      check("start1", 32'(task_start), 32'b010);
      run_task(1, 3'b001, 1'b0);
      check("start2", 32'(task_start), 32'b100);
      run_task(2, 3'b011, 1'b0);
      exp_fc = 1;
      check("seq_busy_low", 32'(busy), 32'd0);
      check("seq_fc", 32'(frame_count), 32'(exp_fc));
      check("seq_no_start", 32'(task_start), 32'd0);
      step();
      check("seq_fc_hold", 32'(frame_count), 32'(exp_fc));

      // Sparse mask skips task 1
      arm_frame(3'b101);
      step();
      check("m101_start0", 32'(task_start), 32'b001);
      run_task(0, 3'b010, 1'b0);
      check("m101_start2", 32'(task_start), 32'b100);
      run_task(2, 3'b000, 1'b0);
      exp_fc = 2;
      check("m101_fc", 32'(frame_count), 32'(exp_fc));
      check("m101_busy", 32'(busy), 32'd0);

      // Empty mask: count only
      arm_frame(3'b000);
      check("m000_busy_n", 32'(busy), 32'd0);
      step();
      exp_fc = 3;
      check("m000_fc", 32'(frame_count), 32'(exp_fc));
      check("m000_busy", 32'(busy), 32'd0);
      step();
      check("m000_fc_hold", 32'(frame_count), 32'(exp_fc));

      // Display-active collision while task 1 is outstanding
      arm_frame(3'b011);
      step();
      check("ovr_start0", 32'(task_start), 32'b001);
      run_task(0, 3'b000, 1'b0);
      check("ovr_start1", 32'(task_start), 32'b010);
      step();
      de = 1'b1;
      step();
      de = 1'b0;
      check("ovr_set", 32'(overrun), 32'(exp_ovr));
      overrun_clear = 1'b1;
      de            = 1'b1;
      step();
      overrun_clear = 1'b0;
      de            = 1'b0;
      check("ovr_set_wins", 32'(overrun), 32'(exp_ovr));
      check("ovr_still_busy", 32'(busy), 32'd1);
      task_done = 3'b010;
      step();
      task_done = '0;
      exp_fc = 4;
      check("ovr_seq_done", 32'(busy), 32'd0);
      check("ovr_fc", 32'(frame_count), 32'(exp_fc));
      check("ovr_sticky", 32'(overrun), 32'(exp_ovr));
      overrun_clear = 1'b1;
      step();
      overrun_clear = 1'b0;
      check("ovr_cleared", 32'(overrun), 32'd0);

      // Counter wrap with empty frames
      while (exp_fc != 0) begin
         arm_frame(3'b000);
         step();
         exp_fc = (exp_fc + 1) % (1 << FCW);
      end
      check("fc_wrap", 32'(frame_count), 32'd0);
      check("fc_wrap_ovr", 32'(overrun), 32'd0);

      // Reset while waiting on task 1
      arm_frame(3'b111);
      step();
      check("rstmid_start0", 32'(task_start), 32'b001);
      run_task(0, 3'b000, 1'b0);
      check("rstmid_start1", 32'(task_start), 32'b010);
      step();
      rst = 1'b1;
      #1;
      check("rstmid_busy_in_rst", 32'(busy), 32'd0);
      step();
      rst = 1'b0;
      void'(exp_q.pop_back());
      check("rstmid_fc", 32'(frame_count), 32'd0);
      check("rstmid_busy", 32'(busy), 32'd0);
      check("rstmid_start", 32'(task_start), 32'd0);
      check("rstmid_ovr", 32'(overrun), 32'd0);
      task_done = 3'b111;
      step();
      task_done = '0;
      repeat (5) step();
      check("rstmid_idle_busy", 32'(busy), 32'd0);
      check("rstmid_idle_fc", 32'(frame_count), 32'd0);

      check("sb_empty", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/vblank_scheduler.md
VBLANK_SCHEDULER -- requirements
Module: vblank_scheduler

Interface
REQ-001 SHALL have parameter NUM_TASKS, default 3: number of game-logic tasks sequenced per frame (1..8).
REQ-002 SHALL have parameter FRAME_COUNT_WIDTH, default 16: width of completed-frame counter.
REQ-003 SHALL have port clk_rgb  input  1: pixel clock, single clock domain.
REQ-004 SHALL have port rst  input  1: synchronous, active-high reset.
REQ-005 SHALL have port vs  input  1: vertical sync from pixel iterator, high during sync lines.
REQ-006 SHALL have port de  input  1: data enable from pixel iterator, high on active pixels.
REQ-007 SHALL have port task_enable  input  NUM_TASKS: per-task enable mask, sampled at frame start.
REQ-008 SHALL have port task_start  output  NUM_TASKS: one-hot single-cycle start pulse per task.
REQ-009 SHALL have port task_done  input  NUM_TASKS: per-task completion pulse or level.
REQ-010 SHALL have port busy  output  1: high while a frame's task sequence is in progress.
REQ-011 SHALL have port frame_count  output  FRAME_COUNT_WIDTH: count of completed task sequences.
REQ-012 SHALL have port overrun  output  1: sticky flag, task sequence collided with display timing.
REQ-013 SHALL have port overrun_clear  input  1: clears overrun.

Function
REQ-014 SHALL register vs into vs_q each cycle; frame start event = vs high and vs_q low in the same cycle N.
REQ-015 SHALL implement FSM states IDLE, LAUNCH, WAIT; leave IDLE only on a frame start event.
REQ-016 On frame start in cycle N SHALL latch task_enable and assert busy from cycle N+1.
REQ-017 SHALL pulse task_start[i] for exactly one cycle, N+1 for the lowest-index enabled task (state LAUNCH), then enter WAIT.
REQ-018 In WAIT SHALL accept only task_done[i] of the current task, sampled from the cycle after its start pulse; done for other tasks ignored.
REQ-019 On accepted done in cycle M SHALL pulse task_start of the next higher-index enabled task in cycle M+1; disabled tasks skipped with zero cycles.
REQ-020 After the last enabled task's done in cycle M SHALL return to IDLE, drop busy and increment frame_count in cycle M+1.
REQ-021 With latched mask all zero SHALL issue no start pulses, increment frame_count in cycle N+1, busy never asserted.
REQ-022 frame_count SHALL wrap from all-ones to zero without flagging.
REQ-023 Frame start events while busy SHALL be ignored (no restart, no second sequence).
REQ-024 task_enable changes while busy SHALL not affect the running sequence.
REQ-025 At most one task_start bit SHALL be high in any cycle.

Reset
REQ-026 During rst SHALL force state IDLE, task_start 0, busy 0, frame_count 0, overrun 0, latched mask 0.
REQ-027 SHALL reset vs_q to 1 so vs held high across reset release produces no frame start event.
REQ-028 rst mid-sequence SHALL abandon the current task with no further start pulses and no frame_count increment.

Configuration
REQ-029 Macro VBLANK_SCHEDULER_OVERRUN_EN defined: overrun sets when busy and (de high or frame start event) in the same cycle; sequence continues, not aborted.
REQ-030 With VBLANK_SCHEDULER_OVERRUN_EN defined: overrun_clear clears overrun next cycle; simultaneous set and clear leaves overrun set.
REQ-031 Macro undefined: overrun tied 0, overrun_clear ignored, no detection logic synthesised.

Structure
REQ-032 Shared package display_pkg SHALL hold the FSM state typedef and the default NUM_TASKS and FRAME_COUNT_WIDTH constants.
REQ-033 Sub-module rise_detect (registered rising-edge detector, configurable reset value) SHALL generate the frame start event.

Verification
REQ-034 Reset release with vs=1, task_enable=3'b111 -> no task_start until vs falls and rises again.
REQ-035 vs rises cycle 10, mask 3'b111, each done 4 cycles after start -> start[0] cycle 11, start[1] cycle 16, start[2] cycle 21, busy low and frame_count=1 at cycle 26.
REQ-036 Mask 3'b101 -> start[0] then start[2] the cycle after done[0]; start[1] never asserted.
REQ-037 Mask 3'b000, vs edge -> no start pulses, frame_count increments by 1 next cycle, busy stays 0.
REQ-038 (Macro defined) task 1 held not done until de rises -> overrun=1, sequence completes later; overrun_clear and de high same cycle -> overrun stays 1; clear alone -> 0 next cycle.
REQ-039 frame_count preloaded near wrap via 65536 sequences with FRAME_COUNT_WIDTH=16 -> reads 0 with no overrun; rst pulse while waiting task 1 -> all outputs 0, no stray start.
